// File: rtl/prio_enc_pkg.sv
// ----------------------------------------------------------------------------
// prio_enc_pkg
// Shared definitions for the registered priority encoder:
//   - priority mode constants (fixed / round-robin)
//   - onehot_to_idx : index of the single set bit of a one-hot vector
//   - popcount      : number of set bits in a vector
// Both helpers take a 32-bit operand, so request vectors up to 32 lines wide
// are supported by zero-extending into them.
// ----------------------------------------------------------------------------
package prio_enc_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    // OR-reduction of the bit positions; exact for a one-hot operand.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 32'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_encoder_q_if.sv
// ----------------------------------------------------------------------------
// prio_encoder_q_if
// Request / grant bundle for prio_encoder_q.
//   req_in, req_valid : request vector and its qualifier (into the encoder)
//   out_valid, out_idx, out_multi, out_ready : grant handshake
//   pending, merge_cnt : status visibility
// Modports: master = request source and consumer, slave = the encoder.
// ----------------------------------------------------------------------------
interface prio_encoder_q_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0]     req_in;
    logic             req_valid;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_idx;
    logic             out_multi;
    logic [N-1:0]     pending;
    logic [CNT_W-1:0] merge_cnt;

    modport master (
        output req_in, req_valid, out_ready,
        input  out_valid, out_idx, out_multi, pending, merge_cnt
    );

    modport slave (
        input  req_in, req_valid, out_ready,
        output out_valid, out_idx, out_multi, pending, merge_cnt
    );
endinterface

// File: rtl/prio_select.sv
// ----------------------------------------------------------------------------
// prio_select
// Purely combinational winner selection over the registered pending set.
//   pending_i : pending request set
//   rr_ptr_i  : round-robin start position (ignored in fixed mode)
//   mode_i    : 0 = lowest index wins, 1 = first set index at/above rr_ptr_i
//   idx_o     : selected index (only meaningful when found_o)
//   found_o   : pending_i is non-zero
// ----------------------------------------------------------------------------
module prio_select
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] pending_i,
    input  logic [W-1:0] rr_ptr_i,
    input  logic         mode_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);
    logic [N-1:0] ptr_bit;
    logic [N-1:0] above;
    logic [N-1:0] cand;
    logic [N-1:0] lowest;

    // Round-robin search with wrap: prefer the lowest set bit at or above the
    // pointer; if there is none, the wrapped search reduces to the lowest set
    // bit of the whole vector. rr_ptr_i is always < N, so no index >= N is
    // ever produced even for non-power-of-two N.
    // NOTE: blocking assignments in combinational logic, with every output
    // assigned on every path so no latch is inferred.
    always_comb begin
        ptr_bit = N'(1) << rr_ptr_i;
        above   = pending_i & ~(ptr_bit - N'(1));
        cand    = (mode_i && (|above)) ? above : pending_i;
        lowest  = cand & (~cand + N'(1));
        idx_o   = W'(onehot_to_idx(32'(lowest)));
        found_o = |pending_i;
    end

endmodule

// File: rtl/prio_encoder_q.sv
// ----------------------------------------------------------------------------
// prio_encoder_q
// Registered N-line priority encoder with a pending set and a valid/ready
// output. Requests accumulate in the pending set; one index is granted per
// accepted handshake, either lowest-index-first (RR=0) or round-robin (RR=1).
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : prio_encoder_q_if.slave (requests, grant handshake, status)
// Parameters: N request lines (2..32), RR priority mode, CNT_W merge-counter
// width. The index width is derived from N.
// ----------------------------------------------------------------------------
module prio_encoder_q
    import prio_enc_pkg::*;
#(
    parameter int N     = 8,
    parameter int RR    = PRIO_FIXED,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    prio_encoder_q_if.slave       bus
);
    localparam int W = $clog2(N);

    logic [N-1:0]     pending_q,   pending_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_idx_q,   out_idx_d;
    logic             out_multi_q, out_multi_d;
    logic [CNT_W-1:0] merge_cnt_q, merge_cnt_d;
    logic [W-1:0]     rr_ptr_q,    rr_ptr_d;

    logic [W-1:0]     sel_idx;
    logic             sel_found;
    logic             load;
    logic [N-1:0]     add;
    logic [N-1:0]     grant_mask;

    prio_select #(
        .N (N),
        .W (W)
    ) u_select (
        .pending_i (pending_q),
        .rr_ptr_i  (rr_ptr_q),
        .mode_i    (RR == PRIO_RR),
        .idx_o     (sel_idx),
        .found_o   (sel_found)
    );

    always_comb begin
        pending_d   = pending_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_multi_d = out_multi_q;
        merge_cnt_d = merge_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        grant_mask  = '0;

        // The output register may take a new index when it is empty or its
        // current content is being consumed in this cycle.
        load = !out_valid_q || bus.out_ready;
        add  = bus.req_valid ? bus.req_in : '0;

        if (load) begin
            if (sel_found) begin
                out_valid_d = 1'b1;
                out_idx_d   = sel_idx;
                out_multi_d = popcount(32'(pending_q)) > 1;
                grant_mask  = N'(1) << sel_idx;
                if (RR == PRIO_RR) begin
                    rr_ptr_d = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
                end
            end else begin
                // Index and multi flag keep their last values when idle.
                out_valid_d = 1'b0;
            end
        end

        // A re-request of a bit that stays pending is a merged duplicate; one
        // count per cycle regardless of how many bits merged.
        if ((|(add & pending_q & ~grant_mask)) && (merge_cnt_q != '1)) begin
            merge_cnt_d = merge_cnt_q + CNT_W'(1);
        end

        // OR-ing add last lets a same-cycle re-request override its grant.
        pending_d = (pending_q & ~grant_mask) | add;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_multi_q <= 1'b0;
            merge_cnt_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_multi_q <= out_multi_d;
            merge_cnt_q <= merge_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_multi = out_multi_q;
    assign bus.pending   = pending_q;
    assign bus.merge_cnt = merge_cnt_q;

endmodule
